// File: rtl/instr_fetch_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package instr_fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int ADDR_LSB = 2;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Clears the byte-offset bits so every fetch address is word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding request/grant/
// response handshake with instruction memory and buffers the returned word for
// the IF/ID register. Branch redirects override everything; a response that was
// already in flight when a redirect hit is marked killed and dropped on arrival.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [31:0]        pc_out,
    output logic [INSTR_W-1:0] instruction,
    output logic               if_valid
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               full_q, full_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pcp4_q, pcp4_d;

    logic               consume;
    logic               req;
    logic               grant;
    logic               load;
    logic [31:0]        pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // IF/ID takes the buffered word on any unfrozen edge while it is full.
    assign consume = full_q & ~freeze;

    // Only ask for a new word when the buffer will have room for it; held low
    // during reset so nothing is granted while the fetch state is being cleared.
    assign req   = rst & (state_q == REQ) & (~full_q | ~freeze);
    assign grant = req & imem_gnt;

    // Next-state logic: FSM, kill tracking, PC advance and buffer load/consume.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        full_d  = full_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        load    = 1'b0;

        case (state_q)
            REQ: begin
                if (grant) begin
                    state_d = WAIT;
                    kill_d  = branch_taken;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    load    = ~kill_q & ~branch_taken;
                end else if (branch_taken) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (load) begin
            instr_d = imem_rdata;
            pcp4_d  = pc_plus4;
        end

        if (branch_taken) begin
            pc_d   = word_align(branch_addr);
            full_d = 1'b0;
        end else if (load) begin
            pc_d   = pc_plus4;
            full_d = 1'b1;
        end else if (consume) begin
            full_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= REQ;
            pc_q    <= word_align(RESET_PC);
            kill_q  <= 1'b0;
            full_q  <= 1'b0;
            instr_q <= NOP;
            pcp4_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            full_q  <= full_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
        end
    end

    // Outputs are forced to their idle values for the whole reset cycle, not
    // just after the reset edge, so IF/ID never sees a stale word.
    assign imem_req    = req;
    assign imem_addr   = rst ? pc_q : word_align(RESET_PC);
    assign pc_out      = rst ? pcp4_q : '0;
    assign instruction = rst ? instr_q : NOP;
    assign if_valid    = rst & full_q & ~branch_taken;

endmodule
